// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone read-burst master that streams a circular memory buffer into a FIFO.
// Optional macro WB_STREAM_WRITER_BUF_END_EOB_EN: also flags the buffer-end beat with cti=111.
module wb_stream_writer_ctrl #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  output logic [WB_DW-1:0]     fifo_d,
  output logic                 fifo_wr,
  input  logic [FIFO_AW:0]     fifo_cnt,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  input  logic                 continuous,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BCW = $clog2(MAX_BURST_LEN + 1);
  localparam int RW  = ((WB_AW > FIFO_AW + 1) ? WB_AW : FIFO_AW + 1) + 1;
  localparam logic [WB_AW-1:0] STEP       = WB_AW'(WB_DW / 8);
  localparam logic [RW-1:0]    FIFO_DEPTH = RW'(1) << FIFO_AW;

`ifdef WB_STREAM_WRITER_BUF_END_EOB_EN
  localparam bit EOB_AT_BUF_END = 1'b1;
`else
  localparam bit EOB_AT_BUF_END = 1'b0;
`endif

  generate
    if (FIFO_AW <= 0) begin : g_bad_fifo_aw
      $error("wb_stream_writer_ctrl: FIFO_AW must be > 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [WB_AW-1:0]   adr_reg;
  logic [BCW-1:0]     burst_cnt_reg;
  logic [WB_AW-1:0]   wbm_adr_reg;
  logic [2:0]         cti_reg;
  logic               cyc_reg;
  logic [WB_DW-1:0]   fifo_d_reg;
  logic               fifo_wr_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  logic [RW-1:0]      room;
  logic               can_start;
  logic               last_word;
  logic               last_beat;
  logic               beat_ok;
  logic [WB_AW-1:0]   adr_next;
  logic [BCW-1:0]     burst_cnt_next;
  logic               eob_start;
  logic               eob_next;

  always_comb begin
    room           = FIFO_DEPTH - RW'(fifo_cnt);
    can_start      = enable && (burst_size != '0) && (room >= RW'(burst_size));
    last_word      = (adr_reg == buf_size - WB_AW'(1));
    last_beat      = (WB_AW'(burst_cnt_reg) == burst_size - WB_AW'(1));
    beat_ok        = wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    adr_next       = last_word ? '0 : adr_reg + WB_AW'(1);
    burst_cnt_next = burst_cnt_reg + BCW'(1);
    // cti for the first beat of a burst and for the beat following an ack
    eob_start      = (burst_size == WB_AW'(1)) || (EOB_AT_BUF_END && last_word);
    eob_next       = (WB_AW'(burst_cnt_next) == burst_size - WB_AW'(1)) ||
                     (EOB_AT_BUF_END && (adr_next == buf_size - WB_AW'(1)));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= S_IDLE;
      adr_reg       <= '0;
      burst_cnt_reg <= '0;
      wbm_adr_reg   <= '0;
      cti_reg       <= 3'b000;
      cyc_reg       <= 1'b0;
      fifo_d_reg    <= '0;
      fifo_wr_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      fifo_wr_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!enable) begin
            adr_reg <= '0;
          end else if (can_start) begin
            state_reg     <= S_ACTIVE;
            cyc_reg       <= 1'b1;
            busy_reg      <= 1'b1;
            burst_cnt_reg <= '0;
            wbm_adr_reg   <= start_adr + adr_reg * STEP;
            cti_reg       <= eob_start ? 3'b111 : 3'b010;
          end
        end

        S_ACTIVE: begin
          if (wbm_err_i) begin
            // Bus error aborts the run; the beat is discarded
            state_reg     <= S_DONE;
            cyc_reg       <= 1'b0;
            cti_reg       <= 3'b000;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b1;
            burst_cnt_reg <= '0;
          end else if (beat_ok) begin
            fifo_wr_reg   <= 1'b1;
            fifo_d_reg    <= wbm_dat_i;
            adr_reg       <= adr_next;
            burst_cnt_reg <= burst_cnt_next;
            wbm_adr_reg   <= start_adr + adr_next * STEP;
            if (last_word && !continuous) begin
              state_reg     <= S_DONE;
              cyc_reg       <= 1'b0;
              cti_reg       <= 3'b000;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              burst_cnt_reg <= '0;
            end else if (last_beat || last_word) begin
              state_reg     <= S_GAP;
              cyc_reg       <= 1'b0;
              cti_reg       <= 3'b000;
              burst_cnt_reg <= '0;
            end else begin
              cti_reg <= eob_next ? 3'b111 : 3'b010;
            end
          end
        end

        S_GAP: begin
          // One idle cycle lets fifo_cnt catch up with the final write
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          if (!enable) begin
            adr_reg <= '0;
          end
        end

        S_DONE: begin
          if (!enable) begin
            state_reg <= S_IDLE;
            err_reg   <= 1'b0;
            adr_reg   <= '0;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          cyc_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WB_DW / 8; gi++) begin : g_sel
      assign wbm_sel_o[gi] = cyc_reg;
    end
  endgenerate

  assign wbm_adr_o = wbm_adr_reg;
  assign wbm_dat_o = '0;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_cti_o = cti_reg;
  assign wbm_bte_o = 2'b00;
  assign fifo_d    = fifo_d_reg;
  assign fifo_wr   = fifo_wr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
